// File: rtl/load_unit.sv
// load_unit: effective-address generation, single word read over a
// valid/ready memory port, lane extraction/extension and write-back.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : decoded load handshake (rs1_data, imm, rd, load_control)
//   mem_req_valid/ready: word-aligned read request on mem_addr
//   mem_rsp_valid      : read data strobe for mem_rdata
//   wb_valid/rd/data   : one-cycle write-back strobe and payload
//   misaligned         : fault strobe, coincident with wb_valid
module load_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [11:0]       imm,
   input  logic [4:0]        rd,
   input  logic [2:0]        load_control,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic              misaligned
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_WB,
      S_FAULT
   } state_t;

   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_ea;
   logic [ADDR_W-1:0] w_ea;
   logic [4:0]        r_rd;
   logic [2:0]        r_ctl;
   logic [4:0]        r_wb_rd;
   logic [XLEN-1:0]   r_wb_data;
   logic [XLEN-1:0]   w_ext;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic              w_accept;
   logic              w_mis;

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_ea     = rs1_data[ADDR_W-1:0]
                   + {{(ADDR_W-12){imm[11]}}, imm};

   // Alignment is judged on the unregistered address so the fault
   // path can skip the memory request entirely.
   always_comb begin
      w_mis = 1'b0;
      case (load_control)
         LH, LHU: w_mis = w_ea[0];
         LW:      w_mis = |w_ea[1:0];
         default: w_mis = 1'b0;
      endcase
   end

   assign w_byte = mem_rdata[{r_ea[1:0], 3'b000} +: 8];
   assign w_half = mem_rdata[{r_ea[1], 4'b0000} +: 16];

   always_comb begin
      w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      case (r_ctl)
         LH:      w_ext = {{(XLEN-16){w_half[15]}}, w_half};
         LW:      w_ext = mem_rdata;
         LBU:     w_ext = {{(XLEN-8){1'b0}}, w_byte};
         LHU:     w_ext = {{(XLEN-16){1'b0}}, w_half};
         default: w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = w_mis ? S_FAULT : S_REQ;
         end
         S_REQ: begin
            if (mem_req_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid) w_next = S_WB;
         end
         S_WB:    w_next = S_IDLE;
         S_FAULT: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ea      <= '0;
         r_rd      <= '0;
         r_ctl     <= '0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_ea  <= w_ea;
            r_rd  <= rd;
            r_ctl <= load_control;
            if (w_mis) begin
               r_wb_rd   <= rd;
               r_wb_data <= '0;
            end
         end
         if (r_state == S_WAIT && mem_rsp_valid) begin
            r_wb_rd   <= r_rd;
            // x0 is hardwired to zero, so its write-back carries zero.
            r_wb_data <= (r_rd == 5'd0) ? '0 : w_ext;
         end
      end
   end

   assign req_ready     = (r_state == S_IDLE);
   assign mem_req_valid = (r_state == S_REQ);
   assign mem_addr      = {r_ea[ADDR_W-1:2], 2'b00};
   assign wb_valid      = (r_state == S_WB) || (r_state == S_FAULT);
   assign misaligned    = (r_state == S_FAULT);
   assign wb_rd         = r_wb_rd;
   assign wb_data       = r_wb_data;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed stimulus for load_unit with a write-back
// scoreboard; expected results are queued when each load is issued.
module tb_load_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] rs1_data;
   logic [11:0] imm;
   logic [4:0]  rd;
   logic [2:0]  load_control;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        misaligned;

   int n_pass = 0;
   int n_total = 0;
   int hs_cnt = 0;
   int wb_cnt = 0;
   int n_pushed = 0;

   logic [37:0] sb_q[$];

   load_unit #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .rs1_data(rs1_data), .imm(imm), .rd(rd),
      .load_control(load_control),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .misaligned(misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   always @(posedge clk) begin
      if (!rst && mem_req_valid && mem_req_ready) hs_cnt++;
   end

   always @(negedge clk) begin
      logic [37:0] e;
      if (!rst && wb_valid) begin
         wb_cnt++;
         check("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("wb_rd", {27'd0, wb_rd}, {27'd0, e[37:33]});
            check("wb_data", wb_data, e[32:1]);
            check("misaligned", {31'd0, misaligned}, {31'd0, e[0]});
         end
      end else if (!rst) begin
         check("mis_no_wb", {31'd0, misaligned}, 32'd0);
      end
   end

   task automatic do_load(input logic [31:0] rs1, input logic [11:0] im,
                          input logic [4:0] rdi, input logic [2:0] ctl,
                          input logic [31:0] rdata, input int rq_dly,
                          input int rsp_dly, input logic [31:0] e_addr,
                          input logic [31:0] e_data, input logic e_mis);
      int hs0;
      logic [31:0] d;
      @(negedge clk);
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      rs1_data     = rs1;
      imm          = im;
      rd           = rdi;
      load_control = ctl;
      d = (e_mis || rdi == 5'd0) ? 32'd0 : e_data;
      sb_q.push_back({rdi, d, e_mis});
      n_pushed++;
      hs0 = hs_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      rs1_data  = $urandom;
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (e_mis) begin
         check("fault_strobe", {30'd0, wb_valid, misaligned}, 32'd3);
         check("fault_noreq", {31'd0, mem_req_valid}, 32'd0);
         @(negedge clk);
         check("fault_nohs", hs_cnt - hs0, 32'd0);
      end else begin
         check("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
         check("mem_addr", mem_addr, e_addr);
         repeat (rq_dly) begin
            @(negedge clk);
            check("addr_stable", mem_addr, e_addr);
            check("req_held", {31'd0, mem_req_valid}, 32'd1);
         end
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         check("req_drop", {31'd0, mem_req_valid}, 32'd0);
         repeat (rsp_dly) begin
            @(negedge clk);
            check("wait_no_wb", {31'd0, wb_valid}, 32'd0);
            check("wait_busy", {31'd0, req_ready}, 32'd0);
         end
         mem_rsp_valid = 1'b1;
         mem_rdata     = rdata;
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         mem_rdata     = $urandom;
         check("wb_strobe", {31'd0, wb_valid}, 32'd1);
         check("wb_busy", {31'd0, req_ready}, 32'd0);
         check("one_handshake", hs_cnt - hs0, 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      rs1_data = '0;
      imm = '0;
      rd = '0;
      load_control = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_mem_req", {31'd0, mem_req_valid}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      rst = 1'b0;

      // LB, lane 3, sign-extended
      do_load(32'h1000, 12'h003, 5'd5, 3'd0, 32'h80AA_BBCC, 0, 0,
              32'h1000, 32'hFFFF_FF80, 1'b0);
      // LHU / LH with negative offset, upper half
      do_load(32'h2000, 12'hFFE, 5'd6, 3'd5, 32'h9234_5678, 0, 0,
              32'h1FFC, 32'h0000_9234, 1'b0);
      do_load(32'h2000, 12'hFFE, 5'd7, 3'd1, 32'h9234_5678, 0, 0,
              32'h1FFC, 32'hFFFF_9234, 1'b0);
      // misaligned LW and LH
      do_load(32'h3001, 12'h000, 5'd8, 3'd2, 32'h0, 0, 0,
              32'h0, 32'h0, 1'b1);
      do_load(32'h3003, 12'h000, 5'd9, 3'd1, 32'h0, 0, 0,
              32'h0, 32'h0, 1'b1);
      // stalled request and delayed response
      do_load(32'h0100, 12'h010, 5'd10, 3'd2, 32'h1234_5678, 5, 3,
              32'h0110, 32'h1234_5678, 1'b0);
      // LBU lane 1, LB lane 0
      do_load(32'h0050, 12'h001, 5'd11, 3'd4, 32'h80AA_BBCC, 0, 1,
              32'h0050, 32'h0000_00BB, 1'b0);
      do_load(32'h0050, 12'h000, 5'd12, 3'd0, 32'h80AA_BBCC, 1, 0,
              32'h0050, 32'hFFFF_FFCC, 1'b0);
      // undefined control treated as LB, lane 2
      do_load(32'h0060, 12'h002, 5'd13, 3'd7, 32'h0080_0000, 0, 0,
              32'h0060, 32'hFFFF_FF80, 1'b0);
      // most negative offset
      do_load(32'h1000, 12'h800, 5'd14, 3'd2, 32'h1122_3344, 0, 0,
              32'h0800, 32'h1122_3344, 1'b0);
      // byte load at odd address is never misaligned
      do_load(32'h0071, 12'h002, 5'd15, 3'd4, 32'h7F00_0000, 0, 0,
              32'h0070, 32'h0000_007F, 1'b0);

      // reset while waiting for the response
      @(negedge clk);
      req_valid = 1'b1;
      rs1_data = 32'h200;
      imm = 12'h0;
      rd = 5'd16;
      load_control = 3'd2;
      @(negedge clk);
      req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_req_ready", {31'd0, req_ready}, 32'd1);
      check("abort_mem_req", {31'd0, mem_req_valid}, 32'd0);
      check("abort_mem_addr", mem_addr, 32'd0);
      check("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("abort_wb_rd", {27'd0, wb_rd}, 32'd0);
      check("abort_wb_data", wb_data, 32'd0);
      check("abort_mis", {31'd0, misaligned}, 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      repeat (3) begin
         check("stray_no_wb", {31'd0, wb_valid}, 32'd0);
         check("stray_idle", {31'd0, req_ready}, 32'd1);
         @(negedge clk);
      end

      do_load(32'h0040, 12'h000, 5'd17, 3'd2, 32'hDEAD_BEEF, 0, 0,
              32'h0040, 32'hDEAD_BEEF, 1'b0);
      // x0 destination
      do_load(32'h0044, 12'h000, 5'd0, 3'd2, 32'hFFFF_FFFF, 0, 0,
              32'h0044, 32'hFFFF_FFFF, 1'b0);
      // back-to-back with no idle gap in the stimulus
      do_load(32'h0048, 12'h000, 5'd18, 3'd5, 32'hABCD_0001, 0, 0,
              32'h0048, 32'h0000_0001, 1'b0);

      @(negedge clk);
      @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      check("wb_count", wb_cnt, n_pushed);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Execution end of the load path: consumes the decoded load fields (rs1, rd, imm, load_control) for one load, then:
  - computes the effective address,
  - performs a word read over a valid/ready memory interface,
  - extracts, aligns and sign/zero-extends the addressed byte, half or word,
  - presents the result for register write-back.
- Sits between the decode stage and the data memory port; one load in flight at a time.

Parameters:
XLEN, 32, data/register width (only 32 supported)
ADDR_W, 32, byte address width

Ports:
clk  input  1  clock; single clock domain
rst  input  1  synchronous, active-high reset
req_valid  input  1  decoded load presented
req_ready  output  1  unit can accept a load (high only in IDLE)
rs1_data  input  XLEN  base register value
imm  input  12  signed offset
rd  input  5  destination register
load_control  input  3  LB=3'd0, LH=3'd1, LW=3'd2, LBU=3'd4, LHU=3'd5; any other value treated as LB
mem_req_valid  output  1  memory read request
mem_req_ready  input  1  memory accepts request
mem_addr  output  ADDR_W  word-aligned address (low two bits 0)
mem_rsp_valid  input  1  read data valid
mem_rdata  input  XLEN  32-bit word read
wb_valid  output  1  one-cycle write-back strobe
wb_rd  output  5  write-back register
wb_data  output  XLEN  extended load result
misaligned  output  1  one-cycle fault strobe, coincident with wb_valid

Behaviour:
- Reset: state IDLE. req_ready=1; mem_req_valid=0; mem_addr=0; wb_valid=0; wb_rd=0; wb_data=0; misaligned=0. Reset in any state aborts the load; no write-back; any later mem_rsp_valid is ignored.
- Accept: handshake when req_valid&req_ready at a rising edge.
  - Registered: ea = rs1_data + sign_extend(imm) (mod 2^32), rd, load_control.
  - Misaligned when: LH/LHU with ea[0]=1; LW with ea[1:0]!=0. Byte loads are never misaligned.
- States:
  - IDLE: req_ready=1. On accept, go to FAULT if misaligned, else REQ.
  - REQ: mem_req_valid=1, mem_addr={ea[31:2],2'b00}. Address is held stable until mem_req_ready. On mem_req_valid&mem_req_ready go to WAIT.
  - WAIT: wait for mem_rsp_valid; mem_rsp_valid in any other state is ignored. On mem_rsp_valid, capture the extended result and go to WB.
  - WB: wb_valid=1 for exactly one cycle, then IDLE.
  - FAULT: wb_valid=1, misaligned=1, wb_data=0 for exactly one cycle, then IDLE. No memory request is issued.
- Lane select: byte lane = ea[1:0]; half lane = ea[1].
  - Byte = mem_rdata[8*ea[1:0] +: 8]; half = mem_rdata[16*ea[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- rd=0: the load executes normally; wb_valid pulses with wb_rd=0 and wb_data forced to 0.
- Latency:
  - Accept at edge N → mem_req_valid high in cycle N+1.
  - If mem_req_ready is high in N+1 and mem_rsp_valid in N+2 → wb_valid in N+3.
  - Misaligned → wb_valid in N+1.
- wb_rd/wb_data hold their last values outside wb_valid; only the wb_valid-qualified values are architectural.
- Back-to-back: req_ready is low in REQ/WAIT/WB/FAULT. Next accept is possible in the cycle after the WB/FAULT cycle.

Test Plan:
- LB, rs1_data=0x1000, imm=0x003, mem_rdata=0x80AA_BBCC → mem_addr=0x1000; wb_data=0xFFFF_FF80, wb_rd=rd, misaligned=0.
- LHU, rs1_data=0x2000, imm=0xFFE (−2), mem_rdata=0x9234_5678 → mem_addr=0x1FFC; wb_data=0x0000_9234. Same with LH → 0xFFFF_9234.
- LW, rs1_data=0x3001, imm=0 → no mem_req_valid ever; next cycle wb_valid=1, misaligned=1, wb_data=0. LH with ea=0x3003 → same fault.
- mem_req_ready held low 5 cycles, then rsp after 3 cycles → mem_addr stable throughout; exactly one request handshake; single wb_valid; req_ready low until after WB.
- rst asserted in WAIT, then a stray mem_rsp_valid → no wb_valid; all outputs at reset values; next LW at 0x40 with rdata 0xDEAD_BEEF → wb_data=0xDEAD_BEEF.
- rd=0 LW completes → wb_valid=1, wb_rd=0, wb_data=0.
